// File: rtl/elevator_pkg.sv
// Shared types and constants for the four-landing elevator controller.
package elevator_pkg;

    localparam int NUM_FLOORS        = 4;
    localparam int FLOOR_W           = 2;
    localparam int DEF_TRAVEL_CYCLES = 2;
    localparam int DEF_DOOR_CYCLES   = 2;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(
        input logic [FLOOR_W-1:0] f
    );
        logic [NUM_FLOORS-1:0] oh;
        oh    = '0;
        oh[f] = 1'b1;
        return oh;
    endfunction

    // Preferred direction first, then the other one, else stop.
    function automatic state_t pick_motion(
        input logic pref_up,
        input logic above,
        input logic below
    );
        if (pref_up)
            return above ? MOVE_UP : (below ? MOVE_DOWN : IDLE);
        return below ? MOVE_DOWN : (above ? MOVE_UP : IDLE);
    endfunction

endpackage

// File: rtl/elevator_request_scan.sv
// Combinational scan of the pending call mask relative to one floor.
module elevator_request_scan
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i] = (i > int'(floor));
            below_mask[i] = (i < int'(floor));
        end
    end

    assign any_above = |(pending & above_mask);
    assign any_below = |(pending & below_mask);
    assign here      = pending[floor];

endmodule

// File: rtl/elevator_controller_three_floor.sv
// Single-car elevator controller, four landings, Moore outputs.
// Build option: DOOR_REOPEN_EN lets a current-floor call hold the door open.
module elevator_controller_three_floor
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] floor_request,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  door_open
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    state_t                state, state_nxt;
    logic [FLOOR_W-1:0]    floor_q, floor_nxt, eval_floor;
    logic [NUM_FLOORS-1:0] pending, pending_nxt, clear;
    logic                  dir_up, dir_up_nxt;
    logic [TW-1:0]         travel_cnt, travel_nxt;
    logic [DW-1:0]         door_cnt, door_nxt;
    logic                  arrive, reopen;
    logic                  any_above, any_below, here;

    assign arrive = (state == MOVE_UP || state == MOVE_DOWN)
                 && travel_cnt == TW'(TRAVEL_CYCLES - 1);

    // Decisions on the arrival edge are made against the new floor.
    always_comb begin
        eval_floor = floor_q;
        if (arrive)
            eval_floor = (state == MOVE_UP) ? floor_q + 1'b1
                                            : floor_q - 1'b1;
    end

`ifdef DOOR_REOPEN_EN
    assign reopen = (state == DOOR_OPEN) && floor_request[floor_q];
`else
    assign reopen = 1'b0;
`endif

    elevator_request_scan u_scan (
        .pending   (pending),
        .floor     (eval_floor),
        .any_above (any_above),
        .any_below (any_below),
        .here      (here)
    );

    always_comb begin
        state_nxt  = state;
        floor_nxt  = floor_q;
        dir_up_nxt = dir_up;
        travel_nxt = travel_cnt;
        door_nxt   = door_cnt;
        unique case (state)
            IDLE: begin
                if (here)
                    state_nxt = DOOR_OPEN;
                else
                    state_nxt = pick_motion(1'b1, any_above, any_below);
            end
            MOVE_UP, MOVE_DOWN: begin
                travel_nxt = travel_cnt + 1'b1;
                if (arrive) begin
                    floor_nxt  = eval_floor;
                    travel_nxt = '0;
                    if (here)
                        state_nxt = DOOR_OPEN;
                    else
                        state_nxt = pick_motion(state == MOVE_UP,
                                                any_above, any_below);
                end
            end
            DOOR_OPEN: begin
                if (reopen)
                    door_nxt = DW'(DOOR_CYCLES - 1);
                else if (door_cnt != '0)
                    door_nxt = door_cnt - 1'b1;
                else
                    state_nxt = pick_motion(dir_up, any_above, any_below);
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == DOOR_OPEN && state != DOOR_OPEN)
            door_nxt = DW'(DOOR_CYCLES - 1);
        if (state_nxt == MOVE_UP)
            dir_up_nxt = 1'b1;
        else if (state_nxt == MOVE_DOWN)
            dir_up_nxt = 1'b0;
        // The stop floor is masked for as long as the door is involved.
        clear = '0;
        if (state == DOOR_OPEN || state_nxt == DOOR_OPEN)
            clear = floor_onehot(eval_floor);
        pending_nxt = (pending | floor_request) & ~clear;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            floor_q    <= '0;
            pending    <= '0;
            dir_up     <= 1'b1;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            floor_q    <= floor_nxt;
            pending    <= pending_nxt;
            dir_up     <= dir_up_nxt;
            travel_cnt <= travel_nxt;
            door_cnt   <= door_nxt;
        end
    end

    assign current_floor = floor_q;
    assign move_up       = (state == MOVE_UP);
    assign move_down     = (state == MOVE_DOWN);
    assign door_open     = (state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_controller_three_floor.sv
// Scoreboard bench: random calls and resets against a behavioural car model.
module tb_elevator_controller_three_floor;

    localparam int T = 2;
    localparam int D = 2;
    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    typedef struct packed {
        logic [1:0] floor;
        logic       up;
        logic       dn;
        logic       door;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] floor_request = 4'b0;
    logic [1:0] current_floor;
    logic       move_up;
    logic       move_down;
    logic       door_open;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    int       m_floor;
    int       m_mode;
    int       m_timer;
    int       m_rem;
    bit       m_dir_up;
    bit [3:0] m_pend;

    always #5 clk = ~clk;

    elevator_controller_three_floor #(
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .floor_request (floor_request),
        .current_floor (current_floor),
        .move_up       (move_up),
        .move_down     (move_down),
        .door_open     (door_open)
    );

    function automatic bit calls_toward(int f, bit up);
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && (up ? i > f : i < f))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic head_off(bit up_first);
        if (calls_toward(m_floor, up_first)) begin
            m_mode   = up_first ? M_UP : M_DOWN;
            m_dir_up = up_first;
            m_timer  = 0;
        end else if (calls_toward(m_floor, !up_first)) begin
            m_mode   = up_first ? M_DOWN : M_UP;
            m_dir_up = !up_first;
            m_timer  = 0;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic stop_here();
        m_mode = M_DOOR;
        m_rem  = D;
    endtask

    task automatic model_step(bit r, bit [3:0] req);
        int was;
        bit reopen;
        if (!r) begin
            m_floor  = 0;
            m_mode   = M_IDLE;
            m_timer  = 0;
            m_rem    = 0;
            m_dir_up = 1'b1;
            m_pend   = 4'b0;
            return;
        end
        was    = m_mode;
        reopen = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) stop_here();
                else head_off(1'b1);
            end
            M_UP, M_DOWN: begin
                m_timer++;
                if (m_timer == T) begin
                    m_timer = 0;
                    m_floor = m_floor + ((m_mode == M_UP) ? 1 : -1);
                    if (m_pend[m_floor]) stop_here();
                    else head_off(m_mode == M_UP);
                end
            end
            default: begin
`ifdef DOOR_REOPEN_EN
                reopen = req[m_floor];
`endif
                if (reopen) begin
                    m_rem = D;
                end else begin
                    m_rem--;
                    if (m_rem == 0) head_off(m_dir_up);
                end
            end
        endcase
        m_pend = m_pend | req;
        if (was == M_DOOR || m_mode == M_DOOR)
            m_pend[m_floor] = 1'b0;
    endtask

    task automatic cycle(bit r, bit [3:0] q);
        exp_t e;
        rst           = r;
        floor_request = q;
        model_step(r, q);
        e.floor = 2'(m_floor);
        e.up    = (m_mode == M_UP);
        e.dn    = (m_mode == M_DOWN);
        e.door  = (m_mode == M_DOOR);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 4'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (current_floor !== e.floor || move_up !== e.up ||
                move_down !== e.dn || door_open !== e.door) begin
                fails++;
                $display("FAIL outputs cyc%0d: got floor=%0d up=%b dn=%b door=%b, want floor=%0d up=%b dn=%b door=%b",
                         cyc, current_floor, move_up, move_down, door_open,
                         e.floor, e.up, e.dn, e.door);
            end
        end
    end

    initial begin
        bit       r;
        bit [3:0] q;
        cycle(1'b0, 4'b0001);
        cycle(1'b1, 4'b0001);
        idle(4);
        cycle(1'b1, 4'b1000);
        idle(12);
        cycle(1'b1, 4'b0010);
        idle(10);
        cycle(1'b1, 4'b1000);
        idle(2);
        cycle(1'b1, 4'b0100);
        idle(14);
        cycle(1'b1, 4'b0001);
        idle(5);
        cycle(1'b1, 4'b1000);
        idle(1);
        cycle(1'b1, 4'b1001);
        idle(20);
        cycle(1'b1, 4'b1000);
        idle(5);
        cycle(1'b0, 4'b0000);
        idle(3);
        cycle(1'b1, 4'b0001);
        idle(1);
        cycle(1'b1, 4'b0001);
        cycle(1'b1, 4'b0001);
        idle(4);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 149) != 0);
            q = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            cycle(r, q);
        end
        idle(30);
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
